pc_seq_unit: RTL and testbench

//  Registered program-counter unit for the single-cycle MIPS core: holds PC, computes the

---
 rtl/pc_seq_unit_if.sv | 36 +++
 rtl/pc_seq_unit.sv | 135 +++++++++++++
 tb/tb_pc_seq_unit.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_seq_unit_if.sv
// pc_seq_unit_if: control/fetch-side bundle of the program-counter unit.
//   stall         1   hold PC and RAS this cycle
//   npc_op        3   next-PC operation from the control unit
//   imm           26  J/JAL target[25:0]; branch offset in imm[15:0]
//   zero          1   ALU zero flag for the current branch
//   jr_target     AW  rs value for JR/RET
//   pc            AW  current PC
//   npc           AW  combinational next PC
//   link_addr     AW  pc+4, JAL link data
//   ras_underflow 1   one-cycle pulse after RET on an empty RAS
//   align_err     1   sticky misaligned JR/RET target flag
// master drives the controls (control unit / bench); slave is the PC unit.
interface pc_seq_unit_if #(
  parameter int unsigned AW = 32
);
  logic          stall;
  logic [2:0]    npc_op;
  logic [25:0]   imm;
  logic          zero;
  logic [AW-1:0] jr_target;
  logic [AW-1:0] pc;
  logic [AW-1:0] npc;
  logic [AW-1:0] link_addr;
  logic          ras_underflow;
  logic          align_err;

  modport master (
    output stall, npc_op, imm, zero, jr_target,
    input  pc, npc, link_addr, ras_underflow, align_err
  );

  modport slave (
    input  stall, npc_op, imm, zero, jr_target,
    output pc, npc, link_addr, ras_underflow, align_err
  );
endinterface

// File: rtl/pc_seq_unit.sv
// pc_seq_unit: registered program counter with next-PC selection for the MIPS core.
// Ports:
//   clk   rising-edge clock
//   rstn  asynchronous active-low reset
//   bus   pc_seq_unit_if.slave (controls in; pc/npc/link_addr/flags out)
// Parameters: AW (>= 28, must match the interface AW), RESET_PC, RAS_DEPTH (power of 2, >= 2).
// Optional feature: define PC_RAS_EN to add a return-address stack used by RET; without it
// RET behaves as JR and ras_underflow is tied low.
module pc_seq_unit #(
  parameter int unsigned AW        = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter int unsigned RAS_DEPTH = 4
) (
  input logic             clk,
  input logic             rstn,
  pc_seq_unit_if.slave    bus
);

  typedef enum logic [2:0] {
    OpPlus4 = 3'b000,
    OpBeq   = 3'b001,
    OpJ     = 3'b010,
    OpBne   = 3'b011,
    OpJr    = 3'b100,
    OpJal   = 3'b101,
    OpRet   = 3'b110,
    OpRsvd  = 3'b111
  } npc_op_e;

  npc_op_e       w_op;
  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc4;
  logic [AW-1:0] w_boff;
  logic [AW-1:0] w_btgt;
  logic [AW-1:0] w_jtgt;
  logic [AW-1:0] w_ret_tgt;
  logic [AW-1:0] w_npc;
  logic          w_align_set;
  logic          r_align_err;

  assign w_op   = npc_op_e'(bus.npc_op);
  assign w_pc4  = r_pc + AW'(4);
  assign w_boff = {{(AW-18){bus.imm[15]}}, bus.imm[15:0], 2'b00};
  assign w_btgt = w_pc4 + w_boff;

  // The region bits above the 28-bit jump field only exist when AW > 28.
  if (AW > 28) begin : g_jtgt_hi
    assign w_jtgt = {r_pc[AW-1:28], bus.imm, 2'b00};
  end else begin : g_jtgt_lo
    assign w_jtgt = {bus.imm, 2'b00};
  end

  always_comb begin
    w_npc = w_pc4;
    case (w_op)
      OpBeq:      w_npc = bus.zero ? w_btgt : w_pc4;
      OpBne:      w_npc = bus.zero ? w_pc4 : w_btgt;
      OpJ, OpJal: w_npc = w_jtgt;
      OpJr:       w_npc = bus.jr_target;
      OpRet:      w_npc = w_ret_tgt;
      default:    w_npc = w_pc4;
    endcase
  end

  // Judged on the target actually taken, so a RAS-supplied return is checked too.
  assign w_align_set = !bus.stall && ((w_op == OpJr) || (w_op == OpRet)) &&
                       (w_npc[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc        <= AW'(RESET_PC);
      r_align_err <= 1'b0;
    end else if (!bus.stall) begin
      r_pc        <= w_npc;
      r_align_err <= r_align_err | w_align_set;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

  logic [AW-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_top_idx;
  logic [CW-1:0] r_cnt;
  logic          w_ras_hit;
  logic          w_push;
  logic          w_pop;
  logic          w_uf_d;
  logic          r_ras_uf;

  // r_ptr is the next free slot; the top lives one below it (modulo depth).
  assign w_top_idx = r_ptr - PW'(1);
  assign w_ras_hit = (w_op == OpRet) && (r_cnt != '0);
  assign w_ret_tgt = w_ras_hit ? r_ras[w_top_idx] : bus.jr_target;
  assign w_push    = !bus.stall && (w_op == OpJal);
  assign w_pop     = !bus.stall && w_ras_hit;
  assign w_uf_d    = !bus.stall && (w_op == OpRet) && (r_cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_ras_uf <= 1'b0;
    end else begin
      r_ras_uf <= w_uf_d;
      if (w_push) begin
        r_ptr <= r_ptr + PW'(1);
        // Full stack: the slot overwritten is the oldest entry, depth stays saturated.
        if (r_cnt != CW'(RAS_DEPTH)) r_cnt <= r_cnt + CW'(1);
      end else if (w_pop) begin
        r_ptr <= w_top_idx;
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only read below a valid count.
  always_ff @(posedge clk) begin
    if (w_push) r_ras[r_ptr] <= w_pc4;
  end

  assign bus.ras_underflow = r_ras_uf;
`else
  assign w_ret_tgt         = bus.jr_target;
  assign bus.ras_underflow = 1'b0;
`endif

  assign bus.pc        = r_pc;
  assign bus.npc       = w_npc;
  assign bus.link_addr = w_pc4;
  assign bus.align_err = r_align_err;

endmodule

// File: tb/tb_pc_seq_unit.sv
module tb_pc_seq_unit;
  localparam int unsigned AW    = 32;
  localparam int unsigned Depth = 4;
`ifdef PC_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  localparam logic [2:0] OpPlus4 = 3'd0, OpBeq = 3'd1, OpJ = 3'd2, OpBne = 3'd3,
                         OpJr = 3'd4, OpJal = 3'd5, OpRet = 3'd6;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pc_seq_unit_if #(.AW(AW)) bus ();

  pc_seq_unit #(
    .AW        (AW),
    .RESET_PC  (32'h0000_3000),
    .RAS_DEPTH (Depth)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference state: a plain list of return addresses, newest at the back.
  logic [31:0] m_pc;
  bit          m_aerr;
  bit          m_uf;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_npc(input logic [2:0] op, input logic [25:0] imm,
                                            input logic z, input logic [31:0] jrt);
    logic [31:0] pc4, tgt;
    int off;
    pc4 = m_pc + 32'd4;
    off = int'(signed'(imm[15:0])) * 4;
    tgt = pc4 + 32'(off);
    case (op)
      OpBeq:      return z ? tgt : pc4;
      OpBne:      return z ? pc4 : tgt;
      OpJ, OpJal: return {m_pc[31:28], imm, 2'b00};
      OpJr:       return jrt;
      OpRet:      return (RasEn && m_ras.size() > 0) ? m_ras[$] : jrt;
      default:    return pc4;
    endcase
  endfunction

  // Called #1 after a rising edge; drives one cycle and checks both phases.
  task automatic cyc(input logic [2:0] op, input logic [25:0] imm, input logic z,
                     input logic [31:0] jrt, input logic st, input string tag);
    logic [31:0] e_npc;
    bus.npc_op    = op;
    bus.imm       = imm;
    bus.zero      = z;
    bus.jr_target = jrt;
    bus.stall     = st;
    #1;
    e_npc = model_npc(op, imm, z, jrt);
    check({tag, "/npc"}, bus.npc, e_npc);
    check({tag, "/link"}, bus.link_addr, m_pc + 32'd4);
    @(posedge clk);
    #1;
    if (!st) begin
      if (((op == OpJr) || (op == OpRet)) && (e_npc[1:0] != 2'b00)) m_aerr = 1'b1;
      m_uf = RasEn && (op == OpRet) && (m_ras.size() == 0);
      if (RasEn && op == OpJal) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > Depth) void'(m_ras.pop_front());
      end else if (RasEn && op == OpRet && m_ras.size() > 0) begin
        void'(m_ras.pop_back());
      end
      m_pc = e_npc;
    end else begin
      m_uf = 1'b0;
    end
    check({tag, "/pc"}, bus.pc, m_pc);
    check({tag, "/aerr"}, 32'(bus.align_err), 32'(m_aerr));
    check({tag, "/uf"}, 32'(bus.ras_underflow), 32'(m_uf));
  endtask

  // Asserted between edges; pc must be at the reset vector before any clock arrives.
  task automatic do_reset();
    bus.stall = 1'b1;
    #2 rstn = 1'b0;
    #1;
    check("rst/pc", bus.pc, 32'h0000_3000);
    check("rst/aerr", 32'(bus.align_err), 32'd0);
    check("rst/uf", 32'(bus.ras_underflow), 32'd0);
    m_pc   = 32'h0000_3000;
    m_aerr = 1'b0;
    m_uf   = 1'b0;
    m_ras.delete();
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    check("rst/hold", bus.pc, 32'h0000_3000);
  endtask

  initial begin
    bus.stall     = 1'b1;
    bus.npc_op    = OpPlus4;
    bus.imm       = '0;
    bus.zero      = 1'b0;
    bus.jr_target = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Sequential run, then an asynchronous reset mid-run.
    for (int i = 0; i < 3; i++) cyc(OpPlus4, 26'd0, 1'b0, 32'd0, 1'b0, "plus4");
    check("plus4/end", bus.pc, 32'h0000_300C);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(OpPlus4, 26'd0, 1'b0, 32'd0, 1'b0, "plus4b");
    check("plus4b/end", bus.pc, 32'h0000_300C);

    // Branches at pc=3010 with offset -1 word; stalled so the pc stays put.
    cyc(OpPlus4, 26'd0, 1'b0, 32'd0, 1'b0, "to3010");
    cyc(OpBeq, 26'h000FFFF, 1'b1, 32'd0, 1'b1, "beq_t");
    check("beq_t/npc_c", bus.npc, 32'h0000_3010);
    cyc(OpBeq, 26'h000FFFF, 1'b0, 32'd0, 1'b1, "beq_n");
    check("beq_n/npc_c", bus.npc, 32'h0000_3014);
    cyc(OpBne, 26'h000FFFF, 1'b1, 32'd0, 1'b1, "bne_n");
    check("bne_n/npc_c", bus.npc, 32'h0000_3014);
    cyc(OpBne, 26'h000FFFF, 1'b0, 32'd0, 1'b1, "bne_t");
    check("bne_t/npc_c", bus.npc, 32'h0000_3010);
    cyc(OpBeq, 26'h000FFFF, 1'b1, 32'd0, 1'b0, "beq_go");
    check("beq_go/pc_c", bus.pc, 32'h0000_3010);

    // J then misaligned JR.
    do_reset();
    cyc(OpJ, 26'h0000400, 1'b0, 32'd0, 1'b0, "j");
    check("j/pc_c", bus.pc, 32'h0000_1000);
    cyc(OpJr, 26'd0, 1'b0, 32'h0000_3042, 1'b0, "jr");
    check("jr/pc_c", bus.pc, 32'h0000_3042);
    check("jr/aerr_c", 32'(bus.align_err), 32'd1);

    // Stalled JAL, then release: exactly one push.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(OpJal, 26'h0000800, 1'b0, 32'd0, 1'b1, "jal_st");
    check("jal_st/pc_c", bus.pc, 32'h0000_3000);
    cyc(OpJal, 26'h0000800, 1'b0, 32'd0, 1'b0, "jal");
    check("jal/pc_c", bus.pc, 32'h0000_2000);
`ifdef PC_RAS_EN
    cyc(OpRet, 26'd0, 1'b0, 32'h0000_5000, 1'b0, "ret1");
    check("ret1/pc_c", bus.pc, 32'h0000_3004);
    cyc(OpRet, 26'd0, 1'b0, 32'h0000_5000, 1'b0, "ret_uf");
    check("ret_uf/pc_c", bus.pc, 32'h0000_5000);
    check("ret_uf/uf_c", 32'(bus.ras_underflow), 32'd1);
    cyc(OpPlus4, 26'd0, 1'b0, 32'd0, 1'b0, "uf_clr");
    check("uf_clr/uf_c", 32'(bus.ras_underflow), 32'd0);
`else
    cyc(OpRet, 26'd0, 1'b0, 32'h0000_3100, 1'b0, "ret_jr");
    check("ret_jr/pc_c", bus.pc, 32'h0000_3100);
    check("ret_jr/uf_c", 32'(bus.ras_underflow), 32'd0);
`endif

    // Five nested calls, five returns; overflow drops the oldest.
    do_reset();
    for (int k = 1; k <= 5; k++) cyc(OpJal, 26'(k * 32'h100), 1'b0, 32'd0, 1'b0, "nest_jal");
    for (int k = 0; k < 5; k++) cyc(OpRet, 26'd0, 1'b0, 32'h0000_7000, 1'b0, "nest_ret");
    check("nest/pc_c", bus.pc, 32'h0000_7000);
    cyc(OpPlus4, 26'd0, 1'b0, 32'd0, 1'b0, "nest_after");

    // Randomized traffic against the reference model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 120; i++) begin
        logic [2:0]  op;
        logic [31:0] jrt;
        op  = 3'($urandom_range(0, 7));
        jrt = $urandom & 32'hFFFF_FFFC;
        if (op == OpJr && $urandom_range(0, 9) == 0) jrt[1:0] = 2'($urandom_range(1, 3));
        cyc(op, 26'($urandom), 1'($urandom_range(0, 1)), jrt,
            ($urandom_range(0, 4) == 0), "rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
